// File: rtl/dct_axi_pkg.sv
// Shared definitions for the DCT accelerator m00_axi read path.
//   AXI_BURST_INCR / AXI_RESP_OKAY / AXI_CACHE_DEFAULT : AXI encodings.
//   rd_state_e  : read-master FSM states.
//   block_bytes : bytes covered by one burst (one 4x4 pixel block).
package dct_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  function automatic int unsigned block_bytes(input int unsigned burst_len,
                                              input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/dct_sync_fifo.sv
// Single-clock FIFO with a registered output stage.
//   clk, rst      : clock, synchronous active-high reset (pointers/valid only)
//   wr_en/wr_data : push side
//   rd_en         : consumer accepts rd_data when rd_valid is high
//   rd_data/rd_valid : registered head entry
//   full/empty/count : count/full describe the storage array only; the output
//                      register is extra slack on top of DEPTH entries.
module dct_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             load, push;

  always_comb begin
    // Refill the output register whenever it is empty or being consumed.
    load       = (count_q != '0) && (!out_vld_q || rd_en);
    push       = wr_en && ((count_q != (AW+1)'(DEPTH)) || load);
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = load ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(load);
    out_vld_d  = load | (out_vld_q & ~rd_en);
    out_data_d = load ? mem_q[rptr_q] : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
    out_data_q <= out_data_d;
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_vld_q;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0) && !out_vld_q;
  assign count    = count_q;

endmodule

// File: rtl/dct_m00_axi_rd_master.sv
// AXI4 burst-read master feeding the 2D-DCT core: one INCR burst per 4x4
// block, each beat (one 64-bit pixel row) forwarded on an AXI-Stream port.
// Optional macro: DCT_RD_PERF_CNT_EN builds the perf counters; otherwise the
// perf ports are tied to 0.
// Ports:
//   aclk, areset          : clock, synchronous active-high reset
//   start/base_addr/num_blocks : job launch (start ignored while busy)
//   busy/done/error       : status (error sticky until next accepted start)
//   m_axi_ar*             : read address channel (constant burst attributes)
//   m_axi_r*              : read data channel (never backpressured)
//   m_axis_t*             : row stream, tlast on the final row of each block
//   perf_busy_cycles/perf_stall_cycles : performance counters
module dct_m00_axi_rd_master
  import dct_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_BURST_LEN        = 4,
  parameter int C_FIFO_DEPTH       = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                   num_blocks,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [1:0]                    m_axi_rresp,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [31:0]                   perf_busy_cycles,
  output logic [31:0]                   perf_stall_cycles
);

  localparam int unsigned BLOCK_BYTES = block_bytes(C_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam int BC_W  = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    ~(C_M_AXI_ADDR_WIDTH'(BLOCK_BYTES - 1));

  rd_state_e                   state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]                 num_blocks_q, num_blocks_d;
  logic [15:0]                 blk_issued_q, blk_issued_d;
  logic [15:0]                 blk_done_q, blk_done_d;
  logic [CNT_W-1:0]            outst_q, outst_d;
  logic [BC_W-1:0]             beat_cnt_q, beat_cnt_d;
  logic                        error_q, error_d;

  logic                        ar_hs, r_hs, s_hs, last_beat, credit_ok, start_acc;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_full, fifo_empty, fifo_rd_valid;
  logic [C_M_AXI_DATA_WIDTH:0] fifo_rd_data;
  logic                        unused_ok;

  dct_sync_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .wr_en    (r_hs),
    .wr_data  ({m_axi_rdata, last_beat}),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Credit: every beat in flight must already own a FIFO slot, so a new
  // burst is only offered when a whole burst's worth of slots is unclaimed.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outst_q) + SUM_W'(C_BURST_LEN))
                     <= SUM_W'(C_FIFO_DEPTH);

  assign m_axi_arvalid = (state_q == RUN) && credit_ok;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'(C_BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q != IDLE) && !areset;

  assign m_axis_tvalid = fifo_rd_valid;
  assign m_axis_tdata  = fifo_rd_valid ? fifo_rd_data[C_M_AXI_DATA_WIDTH:1] : '0;
  assign m_axis_tlast  = fifo_rd_valid & fifo_rd_data[0];

  assign busy  = (state_q == RUN) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign error = error_q;

  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign s_hs      = m_axis_tvalid && m_axis_tready;
  assign last_beat = (beat_cnt_q == BC_W'(C_BURST_LEN - 1));
  assign start_acc = start && (state_q == IDLE);

  assign unused_ok = ^{m_axi_rid, fifo_full, fifo_empty};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    num_blocks_d = num_blocks_q;
    blk_issued_d = blk_issued_q;
    blk_done_d   = blk_done_q;
    beat_cnt_d   = beat_cnt_q;
    error_d      = error_q;
    outst_d      = outst_q + (ar_hs ? CNT_W'(C_BURST_LEN) : '0) - (r_hs ? CNT_W'(1) : '0);

    if (ar_hs) begin
      addr_d       = addr_q + C_M_AXI_ADDR_WIDTH'(BLOCK_BYTES);
      blk_issued_d = blk_issued_q + 16'd1;
    end
    // Bad responses and misplaced rlast are flagged, but the beat is still
    // forwarded and counted from our own beat counter.
    if (r_hs) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BC_W'(1);
      if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat))
        error_d = 1'b1;
    end
    if (s_hs && m_axis_tlast)
      blk_done_d = blk_done_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          addr_d       = base_addr & ADDR_MASK;
          num_blocks_d = num_blocks;
          blk_issued_d = '0;
          blk_done_d   = '0;
          outst_d      = '0;
          beat_cnt_d   = '0;
          error_d      = 1'b0;
          state_d      = (num_blocks == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (ar_hs && (blk_issued_q + 16'd1 == num_blocks_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (s_hs && m_axis_tlast && (blk_done_q + 16'd1 == num_blocks_q))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      num_blocks_q <= '0;
      blk_issued_q <= '0;
      blk_done_q   <= '0;
      outst_q      <= '0;
      beat_cnt_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      num_blocks_q <= num_blocks_d;
      blk_issued_q <= blk_issued_d;
      blk_done_q   <= blk_done_d;
      outst_q      <= outst_d;
      beat_cnt_q   <= beat_cnt_d;
      error_q      <= error_d;
    end
  end

`ifdef DCT_RD_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (start_acc) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy) perf_busy_d = perf_busy_q + 32'd1;
      // Stall = RUN cycle where no AR handshake can happen.
      if ((state_q == RUN) && (!credit_ok || !m_axi_arready))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dct_m00_axi_rd_master.sv
// Scoreboard bench for dct_m00_axi_rd_master: expected AR addresses and stream
// beats are queued when a job is launched; a memory-slave model and a stream
// monitor pop and compare as handshakes occur.
module tb_dct_m00_axi_rd_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_blocks = '0;
  logic        busy, done, error;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_araddr;
  logic [0:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata = '0;
  logic        m_axi_rlast = 1'b0;
  logic [0:0]  m_axi_rid = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [31:0] perf_busy_cycles, perf_stall_cycles;

  dct_m00_axi_rd_master dut (
    .aclk(aclk), .areset(areset), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done), .error(error),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
    .m_axi_rresp(m_axi_rresp), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .perf_busy_cycles(perf_busy_cycles),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: row k of the block at address a.
  function automatic logic [63:0] mem_row(input logic [31:0] a, input int k);
    return (64'(a) << 16) | 64'(k + 1);
  endfunction

  logic [31:0] exp_ar_q[$];
  logic [64:0] exp_beat_q[$];

  // ---------------- memory slave ----------------
  logic [31:0] rd_q[$];
  int          beat_k = 0;
  bit          ar_pend = 0, r_pend = 0, hold_valid = 0;
  logic [31:0] ar_pend_addr, hold_addr;
  int          inflight = 0, max_inflight = 0, arv_seen = 0;
  logic [31:0] inj_addr = 32'hFFFF_FFFF;
  int          inj_beat = -1;

  always @(negedge aclk) begin
    if (ar_pend) begin
      rd_q.push_back(ar_pend_addr);
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
    end
    if (r_pend) begin
      if (beat_k == 3) begin
        beat_k = 0;
        void'(rd_q.pop_front());
        inflight--;
      end else beat_k++;
    end
    ar_pend = 0;
    r_pend  = 0;
    if (areset) begin
      rd_q.delete();
      beat_k = 0; inflight = 0; hold_valid = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00; m_axi_rdata = '0;
    end else begin
      m_axi_arready = (cyc % 3 != 1);
      if (rd_q.size() > 0 && (cyc % 5 != 3)) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_row(rd_q[0], beat_k);
        m_axi_rlast  = (beat_k == 3);
        m_axi_rresp  = (rd_q[0] == inj_addr && beat_k == inj_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end
      if (m_axi_arvalid) begin
        arv_seen++;
        if (hold_valid) chk("araddr_stable", m_axi_araddr, hold_addr);
        if (m_axi_arready) begin
          ar_pend = 1; ar_pend_addr = m_axi_araddr; hold_valid = 0;
          chk("arlen", m_axi_arlen, 8'd3);
          if (exp_ar_q.size() == 0) chk("ar_unexpected", m_axi_araddr, 64'hDEAD);
          else chk("araddr", m_axi_araddr, exp_ar_q.pop_front());
        end else begin
          hold_valid = 1; hold_addr = m_axi_araddr;
        end
      end else hold_valid = 0;
      r_pend = m_axi_rvalid && m_axi_rready;
    end
  end

  // ---------------- stream monitor ----------------
  bit          stall = 0, chk_done_pend = 0;
  int          blk_out = 0;
  logic [64:0] exp_e;

  always @(negedge aclk) begin
    if (chk_done_pend) begin
      chk("done_after_last", done, 1);
      chk("busy_falls_with_done", busy, 0);
      chk_done_pend = 0;
    end
    m_axis_tready = !stall && (cyc % 7 != 5);
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      if (exp_beat_q.size() == 0) chk("beat_unexpected", m_axis_tdata, 64'hDEAD);
      else begin
        exp_e = exp_beat_q.pop_front();
        chk("tdata", m_axis_tdata, exp_e[64:1]);
        chk("tlast", m_axis_tlast, exp_e[0]);
        if (m_axis_tlast) blk_out++;
        if (exp_beat_q.size() == 0) chk_done_pend = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [31:0] base, input int nb);
    logic [31:0] a;
    a = base & 32'hFFFF_FFE0;
    for (int b = 0; b < nb; b++) begin
      exp_ar_q.push_back(a + 32'(32 * b));
      for (int k = 0; k < 4; k++)
        exp_beat_q.push_back({mem_row(a + 32'(32 * b), k), (k == 3)});
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] nb);
    start = 1'b1; base_addr = base; num_blocks = nb;
    @(posedge aclk); #1;
    start = 1'b0;
    if (nb != 0) begin
      chk("busy_rise", busy, 1);
      chk("arvalid_first", m_axi_arvalid, 1);
      chk("error_cleared", error, 0);
    end else begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
    end
  endtask

  task automatic wait_done(input string name, input int tmo);
    int n;
    n = 0;
    while (!done && n < tmo) begin
      @(posedge aclk); #1; n++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_beats_left"}, exp_beat_q.size(), 0);
    chk({name, "_ars_left"}, exp_ar_q.size(), 0);
    @(posedge aclk); #1;
    chk({name, "_done_pulse"}, done, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_arvalid"}, m_axi_arvalid, 0);
    chk({name, "_rready"}, m_axi_rready, 0);
    chk({name, "_tvalid"}, m_axis_tvalid, 0);
    chk({name, "_tdata"}, m_axis_tdata, 0);
    chk({name, "_tlast"}, m_axis_tlast, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_araddr"}, m_axi_araddr, 0);
    chk({name, "_perf"}, {perf_busy_cycles, perf_stall_cycles}, 0);
    chk({name, "_arlen"}, m_axi_arlen, 8'd3);
    chk({name, "_arsize"}, m_axi_arsize, 3'd3);
    chk({name, "_arburst"}, m_axi_arburst, 2'b01);
    chk({name, "_arcache"}, m_axi_arcache, 4'b0011);
    chk({name, "_arprot"}, m_axi_arprot, 3'b000);
    chk({name, "_arid"}, m_axi_arid, 0);
  endtask

  initial begin
    int n, arv0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    areset = 1'b0;
    @(posedge aclk); #1;

    // Single block with literal expected rows.
    exp_ar_q.push_back(32'h1000);
    exp_beat_q.push_back({64'h0000_0000_1000_0001, 1'b0});
    exp_beat_q.push_back({64'h0000_0000_1000_0002, 1'b0});
    exp_beat_q.push_back({64'h0000_0000_1000_0003, 1'b0});
    exp_beat_q.push_back({64'h0000_0000_1000_0004, 1'b1});
    start_job(32'h1000, 16'd1);
    wait_done("single", 300);
    chk("single_error", error, 0);

    // Eight blocks, consumer stalled for 40 cycles.
    stall = 1; max_inflight = 0;
    push_exp(32'h1000, 8);
    start_job(32'h1000, 16'd8);
    repeat (40) @(posedge aclk);
    #1;
    chk("stall_busy", busy, 1);
    stall = 0;
    wait_done("stall", 3000);
    chk("max_inflight_le4", (max_inflight <= 4), 1);
    chk("stall_error", error, 0);

    // Zero-length job: no AR traffic.
    arv0 = arv_seen;
    start_job(32'h1000, 16'd0);
    @(posedge aclk); #1;
    chk("zero_done_pulse", done, 0);
    repeat (5) @(posedge aclk);
    #1;
    chk("zero_no_arvalid", arv_seen - arv0, 0);

    // SLVERR on block 0, then a clean job clears the flag.
    inj_addr = 32'h2000; inj_beat = 1;
    push_exp(32'h2000, 2);
    start_job(32'h2000, 16'd2);
    wait_done("err", 500);
    chk("err_sticky", error, 1);
    inj_addr = 32'hFFFF_FFFF; inj_beat = -1;
    push_exp(32'h2040, 1);
    start_job(32'h2040, 16'd1);
    wait_done("err_clear", 300);
    chk("err_cleared_after", error, 0);

    // Reset while block 3 is in progress.
    blk_out = 0;
    push_exp(32'h3000, 8);
    start_job(32'h3000, 16'd8);
    n = 0;
    while (blk_out < 2 && n < 3000) begin
      @(posedge aclk); #1; n++;
    end
    chk("reach_block3", (blk_out >= 2), 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    check_reset_outputs("midreset");
    areset = 1'b0;
    exp_ar_q.delete();
    exp_beat_q.delete();
    chk_done_pend = 0;
    repeat (2) @(posedge aclk);
    #1;
    push_exp(32'h4000, 2);
    start_job(32'h4000, 16'd2);
    wait_done("after_reset", 500);
    chk("after_reset_error", error, 0);

    // Misaligned base address is rounded down to the block.
    exp_ar_q.push_back(32'h1000);
    for (int k = 0; k < 4; k++) exp_beat_q.push_back({mem_row(32'h1000, k), (k == 3)});
    start_job(32'h1013, 16'd1);
    wait_done("misaligned", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
